// File: rtl/vid_bbox_detect.sv
// vid_bbox_detect
//   Streaming pass-through with colour-match bounding-box detection.
//   Every Avalon-ST beat on the sink is forwarded to the source through one
//   output register. Video packets (header type 0) are analysed: pixels with
//   R >= R_MIN, G <= G_MAX, B <= B_MAX are counted and their x/y extent is
//   tracked. One cycle after the eop of a video packet, the box is published
//   on bbox_* with a single-cycle bbox_valid strobe.
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   asi_valid/ready/data/sop/eop : sink stream (ready latency 0)
//   aso_valid/ready/data/sop/eop : source stream
//   bbox_min_x/max_x/min_y/max_y : published box limits (11 bit)
//   bbox_count              : published matched-pixel count (20 bit)
//   bbox_found              : at least one match in the published frame
//   bbox_valid              : one-cycle publish strobe
module vid_bbox_detect #(
  parameter int         IMG_W = 640,
  parameter int         IMG_H = 480,
  parameter logic [7:0] R_MIN = 8'd180,
  parameter logic [7:0] G_MAX = 8'd90,
  parameter logic [7:0] B_MAX = 8'd90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        asi_valid,
  output logic        asi_ready,
  input  logic [23:0] asi_data,
  input  logic        asi_sop,
  input  logic        asi_eop,
  output logic        aso_valid,
  input  logic        aso_ready,
  output logic [23:0] aso_data,
  output logic        aso_sop,
  output logic        aso_eop,
  output logic [10:0] bbox_min_x,
  output logic [10:0] bbox_max_x,
  output logic [10:0] bbox_min_y,
  output logic [10:0] bbox_max_y,
  output logic [19:0] bbox_count,
  output logic        bbox_found,
  output logic        bbox_valid
);

  // Coordinates are 11 bits wide, so the frame geometry must fit in them.
  if (IMG_W < 1 || IMG_W > 2048 || IMG_H < 1 || IMG_H > 2048) begin : g_bad_geometry
    $error("vid_bbox_detect: IMG_W and IMG_H must lie in 1..2048");
  end

  // ST_HDR is part of the state set but never entered: the header beat moves
  // straight to VIDEO/SKIP; if ever seen it recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_VIDEO = 2'd2,
    ST_SKIP  = 2'd3
  } state_t;

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [19:0] cnt_q, cnt_d;
  logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;

  logic        aso_valid_q, aso_valid_d, aso_sop_q, aso_sop_d, aso_eop_q, aso_eop_d;
  logic [23:0] aso_data_q, aso_data_d;

  logic [10:0] bb_min_x_q, bb_min_x_d, bb_max_x_q, bb_max_x_d;
  logic [10:0] bb_min_y_q, bb_min_y_d, bb_max_y_q, bb_max_y_d;
  logic [19:0] bb_count_q, bb_count_d;
  logic        bb_found_q, bb_found_d, bb_valid_q, bb_valid_d;

  logic        xfer;
  logic        match;
  logic [10:0] x_nxt, y_nxt;
  logic [19:0] cnt_upd;
  logic [10:0] min_x_upd, max_x_upd, min_y_upd, max_y_upd;

  // Reset forces ready high so upstream is never stalled while reset is held.
  assign asi_ready = reset | ~aso_valid_q | aso_ready;
  assign xfer      = asi_valid & asi_ready;

  // Pixel classification and accumulator update for the current beat.
  always_comb begin
    match = (asi_data[23:16] >= R_MIN) && (asi_data[15:8] <= G_MAX) &&
            (asi_data[7:0] <= B_MAX);
    cnt_upd   = cnt_q;
    min_x_upd = min_x_q;
    max_x_upd = max_x_q;
    min_y_upd = min_y_q;
    max_y_upd = max_y_q;
    if (match) begin
      cnt_upd   = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
      min_x_upd = (x_q < min_x_q) ? x_q : min_x_q;
      max_x_upd = (x_q > max_x_q) ? x_q : max_x_q;
      min_y_upd = (y_q < min_y_q) ? y_q : min_y_q;
      max_y_upd = (y_q > max_y_q) ? y_q : max_y_q;
    end else begin
      cnt_upd = cnt_q;
    end
    // Raster position of the next pixel; y sticks at the top of its range.
    if (x_q == X_LAST) begin
      x_nxt = 11'd0;
      y_nxt = (y_q == 11'h7FF) ? y_q : y_q + 11'd1;
    end else begin
      x_nxt = x_q + 11'd1;
      y_nxt = y_q;
    end
  end

  // Packet FSM, accumulators and publish registers.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    min_x_d    = min_x_q;
    max_x_d    = max_x_q;
    min_y_d    = min_y_q;
    max_y_d    = max_y_q;
    bb_min_x_d = bb_min_x_q;
    bb_max_x_d = bb_max_x_q;
    bb_min_y_d = bb_min_y_q;
    bb_max_y_d = bb_max_y_q;
    bb_count_d = bb_count_q;
    bb_found_d = bb_found_q;
    bb_valid_d = 1'b0;
    if (xfer) begin
      if (asi_sop) begin
        // A header always restarts analysis, discarding any unfinished frame.
        x_d     = 11'd0;
        y_d     = 11'd0;
        cnt_d   = 20'd0;
        min_x_d = 11'h7FF;
        max_x_d = 11'd0;
        min_y_d = 11'h7FF;
        max_y_d = 11'd0;
        if (asi_eop) begin
          state_d = ST_IDLE;
        end else if (asi_data[3:0] == 4'h0) begin
          state_d = ST_VIDEO;
        end else begin
          state_d = ST_SKIP;
        end
      end else begin
        case (state_q)
          ST_VIDEO: begin
            x_d     = x_nxt;
            y_d     = y_nxt;
            cnt_d   = cnt_upd;
            min_x_d = min_x_upd;
            max_x_d = max_x_upd;
            min_y_d = min_y_upd;
            max_y_d = max_y_upd;
            if (asi_eop) begin
              state_d    = ST_IDLE;
              bb_valid_d = 1'b1;
              if (cnt_upd == 20'd0) begin
                bb_found_d = 1'b0;
                bb_min_x_d = 11'd0;
                bb_max_x_d = 11'd0;
                bb_min_y_d = 11'd0;
                bb_max_y_d = 11'd0;
                bb_count_d = 20'd0;
              end else begin
                bb_found_d = 1'b1;
                bb_min_x_d = min_x_upd;
                bb_max_x_d = max_x_upd;
                bb_min_y_d = min_y_upd;
                bb_max_y_d = max_y_upd;
                bb_count_d = cnt_upd;
              end
            end else begin
              state_d = ST_VIDEO;
            end
          end
          ST_SKIP: begin
            if (asi_eop) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SKIP;
            end
          end
          ST_IDLE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Single output register stage; it only loads when the sink side is ready.
  always_comb begin
    aso_valid_d = aso_valid_q;
    aso_data_d  = aso_data_q;
    aso_sop_d   = aso_sop_q;
    aso_eop_d   = aso_eop_q;
    if (asi_ready) begin
      aso_valid_d = asi_valid;
    end else begin
      aso_valid_d = aso_valid_q;
    end
    if (xfer) begin
      aso_data_d = asi_data;
      aso_sop_d  = asi_sop;
      aso_eop_d  = asi_eop;
    end else begin
      aso_data_d = aso_data_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 11'd0;
      y_q         <= 11'd0;
      cnt_q       <= 20'd0;
      min_x_q     <= 11'h7FF;
      max_x_q     <= 11'd0;
      min_y_q     <= 11'h7FF;
      max_y_q     <= 11'd0;
      aso_valid_q <= 1'b0;
      aso_data_q  <= 24'd0;
      aso_sop_q   <= 1'b0;
      aso_eop_q   <= 1'b0;
      bb_min_x_q  <= 11'd0;
      bb_max_x_q  <= 11'd0;
      bb_min_y_q  <= 11'd0;
      bb_max_y_q  <= 11'd0;
      bb_count_q  <= 20'd0;
      bb_found_q  <= 1'b0;
      bb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      aso_valid_q <= aso_valid_d;
      aso_data_q  <= aso_data_d;
      aso_sop_q   <= aso_sop_d;
      aso_eop_q   <= aso_eop_d;
      bb_min_x_q  <= bb_min_x_d;
      bb_max_x_q  <= bb_max_x_d;
      bb_min_y_q  <= bb_min_y_d;
      bb_max_y_q  <= bb_max_y_d;
      bb_count_q  <= bb_count_d;
      bb_found_q  <= bb_found_d;
      bb_valid_q  <= bb_valid_d;
    end
  end

  assign aso_valid  = aso_valid_q;
  assign aso_data   = aso_data_q;
  assign aso_sop    = aso_sop_q;
  assign aso_eop    = aso_eop_q;
  assign bbox_min_x = bb_min_x_q;
  assign bbox_max_x = bb_max_x_q;
  assign bbox_min_y = bb_min_y_q;
  assign bbox_max_y = bb_max_y_q;
  assign bbox_count = bb_count_q;
  assign bbox_found = bb_found_q;
  assign bbox_valid = bb_valid_q;

endmodule
